// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register:
// default widths, bubble PC and control-bundle field positions.
package pipe_pkg;

    localparam int DATA_W_DEF = 69;
    localparam int CTRL_W_DEF = 8;
    localparam int PC_W_DEF   = 32;

    localparam logic [31:0] PC_RST = 32'h8000_0000;

    localparam int CTRL_REGWR  = 0;
    localparam int CTRL_MEMWR  = 1;
    localparam int CTRL_MEMRD  = 2;
    localparam int CTRL_M2R_LO = 3;
    localparam int CTRL_M2R_HI = 4;
    localparam int CTRL_PCS_LO = 5;
    localparam int CTRL_PCS_HI = 7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage register: payload, ctrl, pc, valid.
// clear wipes everything; drop only invalidates so the payload lingers.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              DATA_W = DATA_W_DEF,
    parameter int              CTRL_W = CTRL_W_DEF,
    parameter int              PC_W   = PC_W_DEF,
    parameter logic [PC_W-1:0] RST_PC = pipe_pkg::PC_RST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_drop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [PC_W-1:0]   o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [PC_W-1:0]   r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_pc    <= RST_PC;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_pc    <= RST_PC;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
            r_pc    <= i_pc;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
    assign o_pc    = r_pc;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid buffer between pipeline stages with flush and a
// registered in_ready; an empty stage presents a no-write bubble.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W = DATA_W_DEF,
    parameter int              CTRL_W = CTRL_W_DEF,
    parameter int              PC_W   = PC_W_DEF,
    parameter logic [PC_W-1:0] PC_RST = pipe_pkg::PC_RST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    state_e r_state;
    logic   r_in_ready;

    logic              w_acc;
    logic              w_drn;
    logic              w_hd_load;
    logic              w_hd_from_sk;
    logic              w_hd_drop;
    logic              w_sk_load;
    logic              w_sk_drop;
    logic              w_hd_vld;
    logic [DATA_W-1:0] w_hd_data;
    logic [CTRL_W-1:0] w_hd_ctrl;
    logic [PC_W-1:0]   w_hd_pc;
    logic              w_sk_vld;
    logic [DATA_W-1:0] w_sk_data;
    logic [CTRL_W-1:0] w_sk_ctrl;
    logic [PC_W-1:0]   w_sk_pc;
    logic [DATA_W-1:0] w_hd_in_data;
    logic [CTRL_W-1:0] w_hd_in_ctrl;
    logic [PC_W-1:0]   w_hd_in_pc;

    assign w_acc = in_valid & r_in_ready;
    assign w_drn = w_hd_vld & out_ready;

    always_comb begin
        w_hd_load    = 1'b0;
        w_hd_from_sk = 1'b0;
        w_hd_drop    = 1'b0;
        w_sk_load    = 1'b0;
        w_sk_drop    = 1'b0;
        unique case (r_state)
            ST_EMPTY: w_hd_load = w_acc;
            ST_ONE: begin
                if (w_acc && w_drn) begin
                    w_hd_load = 1'b1;
                end else if (w_acc) begin
                    w_sk_load = 1'b1;
                end else if (w_drn) begin
                    w_hd_drop = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_drn) begin
                    w_hd_load    = 1'b1;
                    w_hd_from_sk = 1'b1;
                    w_sk_drop    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_hd_in_data = w_hd_from_sk ? w_sk_data : in_data;
    assign w_hd_in_ctrl = w_hd_from_sk ? w_sk_ctrl : in_ctrl;
    assign w_hd_in_pc   = w_hd_from_sk ? w_sk_pc   : in_pc;

    // in_ready is a pure function of the next state, so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_acc && !w_drn) begin
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_acc && w_drn) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drn) begin
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .PC_W   (PC_W),
        .RST_PC (PC_RST)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_hd_load),
        .i_clear (flush),
        .i_drop  (w_hd_drop),
        .i_data  (w_hd_in_data),
        .i_ctrl  (w_hd_in_ctrl),
        .i_pc    (w_hd_in_pc),
        .o_valid (w_hd_vld),
        .o_data  (w_hd_data),
        .o_ctrl  (w_hd_ctrl),
        .o_pc    (w_hd_pc)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .PC_W   (PC_W),
        .RST_PC (PC_RST)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_sk_load),
        .i_clear (flush),
        .i_drop  (w_sk_drop),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .i_pc    (in_pc),
        .o_valid (w_sk_vld),
        .o_data  (w_sk_data),
        .o_ctrl  (w_sk_ctrl),
        .o_pc    (w_sk_pc)
    );

    // Skid validity is implied by the state; kept for observability.
    logic w_unused;
    assign w_unused = w_sk_vld;

    assign in_ready  = r_in_ready;
    assign out_valid = w_hd_vld;
    assign out_data  = w_hd_data;
    assign out_ctrl  = w_hd_vld ? w_hd_ctrl : '0;
    assign out_pc    = w_hd_vld ? w_hd_pc : PC_RST;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a two-deep queue model of the stage.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUBBLE_PC = 32'h8000_0000;

    typedef struct packed {
        logic [68:0] d;
        logic [7:0]  c;
        logic [31:0] p;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [68:0] in_data;
    logic [7:0]  in_ctrl;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [68:0] out_data;
    logic [7:0]  out_ctrl;
    logic [31:0] out_pc;
    logic [1:0]  occupancy;

    int errors;
    int checks;

    ent_t        q[$];
    logic [68:0] last_d;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] obs,
                       logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        last_d = '0;
    endtask

    task automatic model_edge();
        bit   acc;
        bit   drn;
        ent_t e;
        if (reset || flush) begin
            model_clear();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) begin
                e = q.pop_front();
                last_d = e.d;
            end
            if (acc) q.push_back({in_data, in_ctrl, in_pc});
        end
    endtask

    task automatic check_all(string tag);
        int n;
        n = q.size();
        chk({tag, "/out_valid"}, out_valid, n > 0);
        chk({tag, "/in_ready"}, in_ready, n < 2);
        chk({tag, "/occupancy"}, occupancy, n);
        if (n > 0) begin
            chk({tag, "/out_ctrl"}, out_ctrl, q[0].c);
            chk({tag, "/out_pc"}, out_pc, q[0].p);
            chk({tag, "/out_data"}, out_data, q[0].d);
        end else begin
            chk({tag, "/out_ctrl"}, out_ctrl, 0);
            chk({tag, "/out_pc"}, out_pc, BUBBLE_PC);
            chk({tag, "/out_data"}, out_data, last_d);
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_payload();
        in_data[31:0]  = $urandom();
        in_data[63:32] = $urandom();
        in_data[68:64] = 5'($urandom());
        in_ctrl        = 8'($urandom());
        in_pc          = $urandom();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check_all("reset");
        #1;
        reset = 1'b0;

        // single accept, one-cycle latency
        in_valid  = 1'b1;
        in_ctrl   = 8'h1F;
        in_pc     = 32'h8000_0004;
        in_data   = 69'h1_2345_6789_ABCD_EF01;
        out_ready = 1'b1;
        step("first");
        chk("first/ctrl_k", out_ctrl, 8'h1F);
        chk("first/pc_k", out_pc, 32'h8000_0004);
        chk("first/occ_k", occupancy, 2'd1);
        in_valid = 1'b0;
        step("drain1");
        chk("drain1/data_hold", out_data,
            69'h1_2345_6789_ABCD_EF01);

        // stall with two entries, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0A0A;
        in_ctrl   = 8'hA1;
        in_data   = 69'hA;
        step("pushA");
        in_pc   = 32'h0000_0B0B;
        in_ctrl = 8'hB2;
        in_data = 69'hB;
        step("pushB");
        chk("full/occ_k", occupancy, 2'd2);
        chk("full/rdy_k", in_ready, 1'b0);
        chk("full/pcA_k", out_pc, 32'h0000_0A0A);
        in_pc = 32'h0000_0C0C;
        step("stall");
        chk("stall/pcA_k", out_pc, 32'h0000_0A0A);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step("popA");
        chk("popA/pcB_k", out_pc, 32'h0000_0B0B);
        step("popB");
        chk("popB/empty_k", out_valid, 1'b0);

        // flush when full, with accept and drain both offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_payload();
        step("fill1");
        rand_payload();
        step("fill2");
        flush     = 1'b1;
        out_ready = 1'b1;
        rand_payload();
        step("flush");
        chk("flush/occ_k", occupancy, 2'd0);
        chk("flush/pc_k", out_pc, 32'h8000_0000);
        chk("flush/rdy_k", in_ready, 1'b1);
        chk("flush/data_k", out_data, 69'h0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step("postflush");

        // back-to-back streaming
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_pc   = 32'h0000_1000 + 32'(i * 4);
            in_data = 69'(i);
            in_ctrl = 8'(i);
            step("stream");
            chk("stream/occ_k", occupancy, 2'd1);
        end
        in_valid = 1'b0;
        step("streamend");

        // asynchronous reset between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_payload();
        step("afill1");
        rand_payload();
        step("afill2");
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check_all("arst");
        chk("arst/pc_k", out_pc, 32'h8000_0000);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h8000_0100;
        in_ctrl   = 8'h3C;
        step("arst_acc");
        chk("arst_acc/pc_k", out_pc, 32'h8000_0100);
        in_valid = 1'b0;
        step("arst_drain");

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            rand_payload();
            step("rand");
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step("final");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
